// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the decode-stage hazard controller: opcode map,
// operand read/write-set helpers, the scoreboard entry record and the
// redirect FSM state type.
// Instruction layout: opcode [15:12], rd [11:8], rs [7:4], rt [3:0].
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam int ISIZE = 16;
   localparam int RSIZE = 4;
   localparam int SEL_W = 3;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LI   = 4'hA;
   localparam logic [3:0] OP_LUI  = 4'hB;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_JAL  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_EXEC = 4'hF;

   typedef struct packed {
      logic             valid;
      logic [RSIZE-1:0] addr;
      logic             is_load;
   } sb_entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_FLUSH
   } redir_state_t;

   function automatic logic reads_rs(input logic [3:0] op);
      return op <= OP_SW;
   endfunction

   function automatic logic reads_rt(input logic [3:0] op);
      return op <= OP_XOR;
   endfunction

   // rd doubles as a source for store data and for register-indirect targets
   function automatic logic reads_rd(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_JR) || (op == OP_EXEC);
   endfunction

   function automatic logic writes_dest(input logic [3:0] op);
      return (op <= OP_LW) || (op == OP_LI) || (op == OP_LUI) || (op == OP_JAL);
   endfunction

   // JAL writes its return address into the fixed link register, not rd
   function automatic logic [RSIZE-1:0] dest_addr(input logic [3:0] op,
                                                  input logic [RSIZE-1:0] rd,
                                                  input logic [RSIZE-1:0] link);
      return (op == OP_JAL) ? link : rd;
   endfunction

   function automatic logic is_redirect_op(input logic [3:0] op, input logic take);
      return (op == OP_JAL) || (op == OP_JR) || (op == OP_EXEC) || ((op == OP_B) && take);
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of in-flight destinations (stage 0 = EX ... last = WB) and
// the nearest-producer match for the three decode operands.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_push                  entry entering stage 0 this clock
//   i_{rs,rt,rd}_en/_addr   operand is read / its register address
//   o_{rs,rt,rd}_sel        0 = register file, k+1 = forward from stage k
//   o_load_hit              some read operand depends on a load in stage 0
// ---------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
#(
   parameter int FWD_DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  sb_entry_t        i_push,
   input  logic             i_rs_en,
   input  logic [RSIZE-1:0] i_rs_addr,
   input  logic             i_rt_en,
   input  logic [RSIZE-1:0] i_rt_addr,
   input  logic             i_rd_en,
   input  logic [RSIZE-1:0] i_rd_addr,
   output logic [SEL_W-1:0] o_rs_sel,
   output logic [SEL_W-1:0] o_rt_sel,
   output logic [SEL_W-1:0] o_rd_sel,
   output logic             o_load_hit
);

   sb_entry_t [FWD_DEPTH-1:0] r_sb;

   // Entries age one stage per clock; the oldest falls off the end.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb <= '0;
      end else begin
         r_sb[0] <= i_push;
         for (int k = 1; k < FWD_DEPTH; k++) begin
            r_sb[k] <= r_sb[k-1];
         end
      end
   end

   // Searching from the oldest stage toward stage 0 lets the youngest
   // producer overwrite the result. A load still in EX has no data yet, so
   // it is skipped here and handled by the stall instead.
   function automatic logic [SEL_W-1:0] pick(input logic en, input logic [RSIZE-1:0] addr);
      logic [SEL_W-1:0] sel;
      sel = '0;
      if (en && (addr != '0)) begin
         for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_sb[k].valid && (r_sb[k].addr == addr) && !((k == 0) && r_sb[k].is_load)) begin
               sel = SEL_W'(k + 1);
            end
         end
      end
      return sel;
   endfunction

   function automatic logic load_hit(input logic en, input logic [RSIZE-1:0] addr);
      return en && (addr != '0) && r_sb[0].valid && r_sb[0].is_load && (r_sb[0].addr == addr);
   endfunction

   // Per-operand forwarding selects and the combined load-use indication.
   always_comb begin
      o_rs_sel   = pick(i_rs_en, i_rs_addr);
      o_rt_sel   = pick(i_rt_en, i_rt_addr);
      o_rd_sel   = pick(i_rd_en, i_rd_addr);
      o_load_hit = load_hit(i_rs_en, i_rs_addr) || load_hit(i_rt_en, i_rt_addr) ||
                   load_hit(i_rd_en, i_rd_addr);
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
// Decode-stage hazard control: operand forwarding selects, one-cycle
// load-use stall and a redirect/flush sequencer for taken control transfers.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_id_valid          decode holds a real instruction
//   i_id_instr          instruction in decode
//   i_id_take           branch condition true (conditional branch only)
//   o_stall             hold PC and IF/ID, bubble into EX
//   o_flush             squash the IF/ID instruction
//   o_redirect          PC takes the branch/jump target this cycle
//   o_fwd_{rs,rt,rd}_sel  0 = register file, k+1 = scoreboard stage k
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int               FWD_DEPTH      = 2,
   parameter int               BRANCH_PENALTY = 1,
   parameter logic [RSIZE-1:0] LINK_REG       = 4'd15
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [ISIZE-1:0] i_id_instr,
   input  logic             i_id_take,
   output logic             o_stall,
   output logic             o_flush,
   output logic             o_redirect,
   output logic [SEL_W-1:0] o_fwd_rs_sel,
   output logic [SEL_W-1:0] o_fwd_rt_sel,
   output logic [SEL_W-1:0] o_fwd_rd_sel
);

   logic [3:0]       w_op;
   logic [RSIZE-1:0] w_rd;
   logic [RSIZE-1:0] w_rs;
   logic [RSIZE-1:0] w_rt;
   logic [RSIZE-1:0] w_dest;
   logic             w_flush;
   logic             w_stall;
   logic             w_redirect;
   logic             w_load_hit;
   logic [SEL_W-1:0] w_rs_sel;
   logic [SEL_W-1:0] w_rt_sel;
   logic [SEL_W-1:0] w_rd_sel;
   sb_entry_t        w_push;

   redir_state_t r_state;
   redir_state_t w_next_state;
   logic [1:0]   r_cnt;
   logic [1:0]   w_next_cnt;

   assign w_op   = i_id_instr[15:12];
   assign w_rd   = i_id_instr[11:8];
   assign w_rs   = i_id_instr[7:4];
   assign w_rt   = i_id_instr[3:0];
   assign w_dest = dest_addr(w_op, w_rd, LINK_REG);

   // Only an instruction that really advances into EX leaves a destination
   // behind; stalled, flushed or r0-writing slots become bubbles.
   always_comb begin
      w_push         = '0;
      w_push.valid   = i_id_valid && !w_stall && !w_flush && writes_dest(w_op) && (w_dest != '0);
      w_push.addr    = w_dest;
      w_push.is_load = (w_op == OP_LW);
   end

   hazard_scoreboard #(
      .FWD_DEPTH (FWD_DEPTH)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (w_push),
      .i_rs_en    (reads_rs(w_op)),
      .i_rs_addr  (w_rs),
      .i_rt_en    (reads_rt(w_op)),
      .i_rt_addr  (w_rt),
      .i_rd_en    (reads_rd(w_op)),
      .i_rd_addr  (w_rd),
      .o_rs_sel   (w_rs_sel),
      .o_rt_sel   (w_rt_sel),
      .o_rd_sel   (w_rd_sel),
      .o_load_hit (w_load_hit)
   );

   // Redirect FSM state register: counter holds remaining flush cycles - 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next state: a redirect opens a flush window of BRANCH_PENALTY cycles.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_redirect) begin
               w_next_state = ST_FLUSH;
               w_next_cnt   = 2'(BRANCH_PENALTY - 1);
            end
         end
         ST_FLUSH: begin
            if (r_cnt == '0) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_cnt = r_cnt - 2'd1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Outputs: stall outranks redirect, nothing fires inside a flush window,
   // and everything is held low while reset is asserted.
   always_comb begin
      w_flush      = (r_state == ST_FLUSH);
      w_stall      = i_id_valid && !w_flush && w_load_hit;
      w_redirect   = (r_state == ST_IDLE) && i_id_valid && !w_stall &&
                     is_redirect_op(w_op, i_id_take);
      o_stall      = !i_rst && w_stall;
      o_flush      = !i_rst && w_flush;
      o_redirect   = !i_rst && w_redirect;
      o_fwd_rs_sel = i_rst ? '0 : w_rs_sel;
      o_fwd_rt_sel = i_rst ? '0 : w_rt_sel;
      o_fwd_rd_sel = i_rst ? '0 : w_rd_sel;
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Directed vector table with hand-derived expectations followed by random
// instruction streams compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

   localparam int         FWD_DEPTH      = 2;
   localparam int         BRANCH_PENALTY = 2;
   localparam logic [3:0] LINK_REG       = 4'd15;

   // Opcode-indexed property masks (bit n = opcode n)
   localparam logic [15:0] RS_MASK  = 16'h03FF;
   localparam logic [15:0] RT_MASK  = 16'h001F;
   localparam logic [15:0] RD_MASK  = 16'hC200;
   localparam logic [15:0] WR_MASK  = 16'h0DFF;
   localparam logic [15:0] JMP_MASK = 16'hE000;

   logic        clk = 1'b0;
   logic        rst;
   logic        idValid;
   logic [15:0] idInstr;
   logic        idTake;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [2:0]  fwdRsSel;
   logic [2:0]  fwdRtSel;
   logic [2:0]  fwdRdSel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        r;
      logic        v;
      logic [15:0] instr;
      logic        take;
      logic        eStall;
      logic        eFlush;
      logic        eRedir;
      logic [2:0]  eRs;
      logic [2:0]  eRt;
      logic [2:0]  eRd;
   } vec_t;

   typedef struct {
      logic       valid;
      logic [3:0] addr;
      logic       isLoad;
   } mEntry_t;

   vec_t    vecs[$];
   mEntry_t mHist[FWD_DEPTH];
   int      mFlushLeft;
   logic    mStall, mFlush, mRedir;
   logic [2:0] mRs, mRt, mRd;

   hazard_ctrl_unit #(
      .FWD_DEPTH      (FWD_DEPTH),
      .BRANCH_PENALTY (BRANCH_PENALTY),
      .LINK_REG       (LINK_REG)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_id_valid   (idValid),
      .i_id_instr   (idInstr),
      .i_id_take    (idTake),
      .o_stall      (stall),
      .o_flush      (flush),
      .o_redirect   (redirect),
      .o_fwd_rs_sel (fwdRsSel),
      .o_fwd_rt_sel (fwdRtSel),
      .o_fwd_rd_sel (fwdRdSel)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
      return {op, rd, rs, rt};
   endfunction

   function automatic vec_t mkVec(input logic r, input logic v, input logic [15:0] instr,
                                  input logic take, input logic eStall, input logic eFlush,
                                  input logic eRedir, input logic [2:0] eRs,
                                  input logic [2:0] eRt, input logic [2:0] eRd);
      vec_t t;
      t.r = r; t.v = v; t.instr = instr; t.take = take;
      t.eStall = eStall; t.eFlush = eFlush; t.eRedir = eRedir;
      t.eRs = eRs; t.eRt = eRt; t.eRd = eRd;
      return t;
   endfunction

   // Reference: youngest in-flight writer of the register, ignoring a load
   // whose data cannot exist yet because it is only now in EX.
   function automatic logic [2:0] modelSel(input logic used, input logic [3:0] a);
      if (!used || a == 4'd0) return 3'd0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
         if (mHist[k].valid && mHist[k].addr == a && !(k == 0 && mHist[k].isLoad))
            return 3'(k + 1);
      end
      return 3'd0;
   endfunction

   function automatic logic modelLoadDep(input logic used, input logic [3:0] a);
      return used && a != 4'd0 && mHist[0].valid && mHist[0].isLoad && mHist[0].addr == a;
   endfunction

   task automatic modelEval();
      logic [3:0] op;
      logic       ctl;
      op  = idInstr[15:12];
      ctl = JMP_MASK[op] || (op == 4'hC && idTake);
      if (rst) begin
         mStall = 0; mFlush = 0; mRedir = 0; mRs = 0; mRt = 0; mRd = 0;
      end else begin
         mFlush = (mFlushLeft > 0);
         mStall = idValid && !mFlush &&
                  (modelLoadDep(RS_MASK[op], idInstr[7:4]) ||
                   modelLoadDep(RT_MASK[op], idInstr[3:0]) ||
                   modelLoadDep(RD_MASK[op], idInstr[11:8]));
         mRedir = idValid && !mFlush && !mStall && ctl;
         mRs    = modelSel(RS_MASK[op], idInstr[7:4]);
         mRt    = modelSel(RT_MASK[op], idInstr[3:0]);
         mRd    = modelSel(RD_MASK[op], idInstr[11:8]);
      end
   endtask

   task automatic modelClock();
      mEntry_t    e;
      logic [3:0] op;
      op = idInstr[15:12];
      if (rst) begin
         for (int k = 0; k < FWD_DEPTH; k++) mHist[k] = '{1'b0, 4'd0, 1'b0};
         mFlushLeft = 0;
      end else begin
         e.isLoad = (op == 4'h8);
         e.addr   = (op == 4'hD) ? LINK_REG : idInstr[11:8];
         e.valid  = idValid && !mFlush && !mStall && (WR_MASK[op] || op == 4'hD) && e.addr != 0;
         for (int k = FWD_DEPTH - 1; k > 0; k--) mHist[k] = mHist[k-1];
         mHist[0] = e;
         if (mFlush) mFlushLeft = mFlushLeft - 1;
         else if (mRedir) mFlushLeft = BRANCH_PENALTY;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle, compare at the falling edge, then advance the model.
   task automatic applyStimulus(input vec_t v, input bit useTable, input int idx);
      string tag;
      rst = v.r; idValid = v.v; idInstr = v.instr; idTake = v.take;
      @(negedge clk);
      modelEval();
      tag = useTable ? $sformatf("vec%0d", idx) : $sformatf("rnd%0d", idx);
      if (useTable) begin
         checkOutput({tag, ".stall"},    stall,    v.eStall);
         checkOutput({tag, ".flush"},    flush,    v.eFlush);
         checkOutput({tag, ".redirect"}, redirect, v.eRedir);
         checkOutput({tag, ".rs_sel"},   fwdRsSel, v.eRs);
         checkOutput({tag, ".rt_sel"},   fwdRtSel, v.eRt);
         checkOutput({tag, ".rd_sel"},   fwdRdSel, v.eRd);
      end else begin
         checkOutput({tag, ".stall"},    stall,    mStall);
         checkOutput({tag, ".flush"},    flush,    mFlush);
         checkOutput({tag, ".redirect"}, redirect, mRedir);
         checkOutput({tag, ".rs_sel"},   fwdRsSel, mRs);
         checkOutput({tag, ".rt_sel"},   fwdRtSel, mRt);
         checkOutput({tag, ".rd_sel"},   fwdRdSel, mRd);
      end
      @(posedge clk);
      modelClock();
      #1;
   endtask

   initial begin
      vec_t rv;
      rst = 1'b1; idValid = 1'b0; idInstr = '0; idTake = 1'b0;
      mFlushLeft = 0;
      for (int k = 0; k < FWD_DEPTH; k++) mHist[k] = '{1'b0, 4'd0, 1'b0};
      @(posedge clk);
      #1;

      //            r  v  instr                       tk st fl rd  rs rt rd
      vecs.push_back(mkVec(1, 1, ins(4'h0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h1, 4, 1, 1), 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, ins(4'h0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h1, 4, 1, 1), 0, 0, 0, 0, 2, 2, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h8, 5, 2, 0), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 6, 5, 0), 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 6, 5, 0), 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 7, 1, 1), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 7, 1, 1), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h3, 8, 7, 7), 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 2, 0, 0), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'hC, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 3, 2, 2), 0, 0, 1, 0, 2, 2, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 4, 3, 3), 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 5, 4, 4), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'hC, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h8, 9, 5, 0), 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'hE, 9, 0, 0), 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'hE, 9, 0, 0), 0, 0, 0, 1, 0, 0, 2));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 1, 2, 3), 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 1, ins(4'h0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, ins(4'h0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));

      $display("[TB] directed vectors");
      foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, i);

      // Reset in the middle of a flush window with a populated scoreboard;
      // the flush-cycle read also proves JAL pushed the link register.
      $display("[TB] reset during flush");
      applyStimulus(mkVec(0, 1, ins(4'hD, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0), 1'b1, 100);
      applyStimulus(mkVec(0, 1, ins(4'h0, 2, 15, 1), 0, 0, 1, 0, 1, 2, 0), 1'b1, 101);
      applyStimulus(mkVec(1, 1, ins(4'h0, 2, 15, 1), 0, 0, 0, 0, 0, 0, 0), 1'b1, 102);
      applyStimulus(mkVec(0, 1, ins(4'h0, 2, 15, 1), 0, 0, 0, 0, 0, 0, 0), 1'b1, 103);
      applyStimulus(mkVec(0, 1, ins(4'h9, 2, 15, 1), 0, 0, 0, 0, 0, 0, 1), 1'b1, 104);

      $display("[TB] random stream vs reference model");
      for (int n = 0; n < 600; n++) begin
         rv.r     = ($urandom_range(0, 99) < 2);
         rv.v     = ($urandom_range(0, 9) < 8);
         rv.instr = ins(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                        4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
         rv.take  = 1'($urandom_range(0, 1));
         rv.eStall = 0; rv.eFlush = 0; rv.eRedir = 0; rv.eRs = 0; rv.eRt = 0; rv.eRd = 0;
         applyStimulus(rv, 1'b0, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline decode-stage control logic.
- Tracks destination registers of in-flight instructions in a FWD_DEPTH-deep scoreboard and generates per-operand forwarding selects, with nearest producer winning.
- Detects load-use hazards and inserts a one-cycle stall plus bubble.
- Runs a redirect FSM that flushes fetch for BRANCH_PENALTY cycles after any taken control transfer (B taken, JAL, JR, EXEC).

Parameters:
- ISIZE, 16, instruction width.
- RSIZE, 4, register address width.
- FWD_DEPTH, 2, scoreboard stages tracked (EX = stage 0 … WB = FWD_DEPTH-1); range 1..4.
- BRANCH_PENALTY, 1, flush cycles after a redirect; range 1..3.
- LINK_REG, 15, destination register written by JAL.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  id_instr holds a real instruction
- id_instr  in  ISIZE  instruction in decode; opcode [15:12], rd [11:8], rs [7:4], rt [3:0]
- id_take  in  1  branch condition true (from flag evaluation), meaningful for opcode 4'hC only
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- flush  out  1  squash the IF/ID instruction
- redirect  out  1  one-cycle pulse: PC takes the branch/jump target
- fwd_rs_sel  out  3  0 = register file; k+1 = forward from scoreboard stage k
- fwd_rt_sel  out  3  same encoding, rt operand
- fwd_rd_sel  out  3  same encoding, rd read as source (SW data, JR/EXEC target)

Behaviour:
- Read sets:
  - rs read by opcodes 0x0–0x9.
  - rt read by 0x0–0x4.
  - rd read by 0x9, 0xE, 0xF.
- Write sets:
  - rd written by 0x0–0x8, 0xA, 0xB.
  - LINK_REG written by 0xD.
  - 0x9, 0xC, 0xE, 0xF write nothing.
- Register 0 never matches as a source or a destination.
- Scoreboard entry per stage: {valid, addr[RSIZE-1:0], is_load}.
  - Each clock, entries shift stage k → k+1; the last stage drops.
  - Stage 0 loads the decoded destination when id_valid && !stall && !flush; otherwise it loads a bubble (valid = 0).
- Forward selects are combinational from id_instr and the registered scoreboard.
  - Select = 1 + smallest k with valid && addr match; 0 if no match.
  - A stage-0 match on an is_load entry never forwards. It raises stall instead.
- Load-use stall:
  - stall = id_valid && !flush && any read operand matches stage 0 with is_load.
  - Duration is exactly one cycle. Next cycle the load sits in stage 1 and the select = 2.
  - While stall = 1, redirect is suppressed. Stall has priority over redirect.
- Redirect FSM (registered), states IDLE and FLUSH with a counter cnt.
  - IDLE:
    - Redirect condition: id_valid && !stall && !flush && (opcode == 0xD || 0xE || 0xF || (opcode == 0xC && id_take)).
    - On the condition, redirect = 1 combinationally that cycle. Next state is FLUSH with cnt = BRANCH_PENALTY-1.
  - FLUSH:
    - flush = 1 and fetched instructions are ignored (no scoreboard push, no stall, no redirect).
    - cnt decrements; at cnt == 0 the FSM returns to IDLE.
  - The JAL destination is still pushed in the redirect cycle.
- Reset (synchronous, any cycle, including mid-FLUSH or mid-stall):
  - Scoreboard is cleared to all invalid.
  - FSM goes to IDLE with cnt = 0.
  - flush = 0.
  - Combinational outputs evaluate to 0 while rst = 1 (stall, redirect, all selects).
- Widths: selects are 3 bits for all legal FWD_DEPTH. Unused codes are never produced.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD … OP_EXEC);
  - read/write-set functions reads_rs, reads_rt, reads_rd, writes_dest, dest_addr;
  - the scoreboard entry struct;
  - the FSM state enum.
- One sub-module, hazard_scoreboard: the shift register plus the priority match for one operand, instantiated three times for rs/rt/rd. Alternatively, one instance with three match ports.

Test Plan:
- ADD r1,r2,r3 then SUB r4,r1,r1 → cycle 2: fwd_rs_sel = 1, fwd_rt_sel = 1, stall = 0. Add a NOP between them → fwd_rs_sel = 2.
- LW r5 then ADD r6,r5,r0 → stall = 1 for one cycle. Next cycle fwd_rs_sel = 2, stall = 0. Scoreboard stage 0 holds a bubble.
- ADD r7 twice (stages 0 and 1 both r7), then OR r8,r7,r7 → select = 1 (nearest wins). Write to r0 followed by a read of r0 → select = 0.
- B with id_take = 1, BRANCH_PENALTY = 2 → redirect pulse in cycle n, flush = 1 in cycles n+1 and n+2. An instruction presented during flush pushes nothing. With id_take = 0 → no redirect.
- LW r9 then JR r9 → stall first with redirect = 0. Next cycle redirect = 1 and fwd_rd_sel = 2.
- Assert rst in the middle of FLUSH with a valid scoreboard → next cycle flush = 0, all selects 0, FSM in IDLE. A following ADD reading any register → select 0.
